// File: rtl/spi_expander_pkg.sv
// Shared definitions for the SPI port-expander controller.
//   state_t     : controller FSM states
//   DEF_*       : default timing parameters
//   max3()      : helper for sizing the shared phase counter
package spi_expander_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        BIT_LO,
        BIT_HI,
        HOLD
    } state_t;

    localparam int unsigned DEF_DIV         = 2;
    localparam int unsigned DEF_CE_SETUP    = 4;
    localparam int unsigned DEF_CE_HOLD     = 4;
    localparam int unsigned DEF_POLL_PERIOD = 1000;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/spi_expander_poll_timer.sv
// Periodic poll request generator for the SPI expander controller.
//   clk, reset   : system clock, asynchronous active-high reset
//   poll_en      : enables counting; low clears counter and pending flag
//   clear        : held high while a transfer starts or is in flight
//   poll_pending : a poll transfer is due
module spi_expander_poll_timer
    import spi_expander_pkg::*;
#(
    parameter int unsigned POLL_PERIOD = DEF_POLL_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic poll_en,
    input  logic clear,
    output logic poll_pending
);

    localparam int unsigned CW = $clog2(POLL_PERIOD);

    logic [CW-1:0] count;

    // The counter is held at zero for the whole transfer, so the poll
    // interval is measured from the end of the previous transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count        <= '0;
            poll_pending <= 1'b0;
        end else if (!poll_en || clear) begin
            count        <= '0;
            poll_pending <= 1'b0;
        end else if (count == CW'(POLL_PERIOD - 1)) begin
            count        <= '0;
            poll_pending <= 1'b1;
        end else begin
            count        <= count + CW'(1);
        end
    end

endmodule

// File: rtl/spi_expander_ctrl.sv
// SPI controller for a 7-out / 3-in shift-register port expander.
// Each transfer shifts out_q MSB first on sin and samples three input
// bits from sout (LSB first) into rdata.
//   clk, reset : system clock, asynchronous active-high reset
//   req, wdata : host write request and 7-bit output value
//   poll_en    : enables periodic transfers resending out_q
//   busy, done : transfer in progress / one-cycle completion pulse
//   rdata      : expander inputs from the last completed transfer
//   sclk, ce, sin, sout : SPI pins (sclk idle high, ce active low)
module spi_expander_ctrl
    import spi_expander_pkg::*;
#(
    parameter int unsigned DIV         = DEF_DIV,
    parameter int unsigned CE_SETUP    = DEF_CE_SETUP,
    parameter int unsigned CE_HOLD     = DEF_CE_HOLD,
    parameter int unsigned POLL_PERIOD = DEF_POLL_PERIOD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [6:0] wdata,
    input  logic       poll_en,
    output logic       busy,
    output logic       done,
    output logic [2:0] rdata,
    output logic       sclk,
    output logic       ce,
    output logic       sin,
    input  logic       sout
);

    localparam int unsigned CNT_MAX = max3(DIV, CE_SETUP, CE_HOLD);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [6:0]       out_q, out_d;
    logic [2:0]       rdata_shadow, shadow_d;
    logic [2:0]       rdata_d;
    logic             sclk_d, ce_d, sin_d, busy_d, done_d;
    logic             start;
    logic             poll_pending;

    spi_expander_poll_timer #(
        .POLL_PERIOD(POLL_PERIOD)
    ) u_poll (
        .clk         (clk),
        .reset       (reset),
        .poll_en     (poll_en),
        .clear       (start | busy),
        .poll_pending(poll_pending)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            out_q        <= '0;
            rdata_shadow <= '0;
            rdata        <= '0;
            sclk         <= 1'b1;
            ce           <= 1'b1;
            sin          <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            out_q        <= out_d;
            rdata_shadow <= shadow_d;
            rdata        <= rdata_d;
            sclk         <= sclk_d;
            ce           <= ce_d;
            sin          <= sin_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

    // Pin values are computed for the state being entered and registered,
    // so every SPI output changes exactly on a state boundary.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        out_d    = out_q;
        shadow_d = rdata_shadow;
        rdata_d  = rdata;
        sclk_d   = sclk;
        ce_d     = ce;
        sin_d    = sin;
        busy_d   = busy;
        done_d   = 1'b0;
        start    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req || poll_pending) begin
                    start   = 1'b1;
                    if (req) out_d = wdata;
                    state_d = SETUP;
                    cnt_d   = '0;
                    ce_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_q == CNT_W'(CE_SETUP - 1)) begin
                    state_d = BIT_LO;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                    sin_d   = out_q[6];
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            BIT_LO: begin
                if (cnt_q == CNT_W'(DIV - 1)) begin
                    if (bit_q < 3'd3) shadow_d[bit_q[1:0]] = sout;
                    state_d = BIT_HI;
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            BIT_HI: begin
                if (cnt_q == CNT_W'(DIV - 1)) begin
                    cnt_d = '0;
                    if (bit_q == 3'd6) begin
                        state_d = HOLD;
                        ce_d    = 1'b1;
                        sin_d   = 1'b0;
                    end else begin
                        state_d = BIT_LO;
                        bit_d   = bit_q + 3'd1;
                        sclk_d  = 1'b0;
                        // next bit index is bit_q+1, i.e. out_q[6-(bit_q+1)]
                        sin_d   = out_q[3'd5 - bit_q];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == CNT_W'(CE_HOLD - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    rdata_d = rdata_shadow;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_expander_ctrl.sv
module tb_spi_expander_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // instance 0: default timing, POLL_PERIOD=50
    logic       req0, poll_en0, busy0, done0, sclk0, ce0, sin0;
    logic       sout0 = 1'b0;
    logic [6:0] wdata0;
    logic [2:0] rdata0;

    // instance 1: fastest timing
    logic       req1, poll_en1, busy1, done1, sclk1, ce1, sin1;
    logic       sout1 = 1'b0;
    logic [6:0] wdata1;
    logic [2:0] rdata1;

    spi_expander_ctrl #(
        .DIV(2), .CE_SETUP(4), .CE_HOLD(4), .POLL_PERIOD(50)
    ) dut0 (
        .clk(clk), .reset(reset), .req(req0), .wdata(wdata0), .poll_en(poll_en0),
        .busy(busy0), .done(done0), .rdata(rdata0), .sclk(sclk0), .ce(ce0),
        .sin(sin0), .sout(sout0)
    );

    spi_expander_ctrl #(
        .DIV(1), .CE_SETUP(3), .CE_HOLD(3), .POLL_PERIOD(1000)
    ) dut1 (
        .clk(clk), .reset(reset), .req(req1), .wdata(wdata1), .poll_en(poll_en1),
        .busy(busy1), .done(done1), .rdata(rdata1), .sclk(sclk1), .ce(ce1),
        .sin(sin1), .sout(sout1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one entry per transfer expected on instance 0.
    // acc = cycle in which the controller accepts the transfer.
    typedef struct {
        int         acc;
        logic [6:0] word;
        logic [2:0] rd;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] exp_q0[$];
    logic [6:0] model_outq = '0;
    logic [2:0] exp1_val   = '0;

    task automatic expect_xfer(input int acc, input logic [6:0] w, input logic [2:0] rd);
        exp_t e;
        e.acc  = acc;
        e.word = w;
        e.rd   = rd;
        sb.push_back(e);
        exp_q0.push_back(rd);
    endtask

    // Expander models: return input bit k on the k-th sclk fall after ce falls.
    logic [2:0] cur0 = '0;
    int         k0   = 0;
    logic       e_pce0 = 1'b1, e_psclk0 = 1'b1;
    always @(negedge clk) begin
        if (e_pce0 && !ce0) begin
            k0 = 0;
            if (exp_q0.size() > 0) cur0 = exp_q0.pop_front();
            else cur0 = 3'b000;
        end
        if (e_psclk0 && !sclk0 && !ce0) begin
            sout0 = (k0 < 3) ? cur0[k0] : 1'b0;
            k0++;
        end
        e_pce0   = ce0;
        e_psclk0 = sclk0;
    end

    int   k1 = 0;
    logic e_pce1 = 1'b1, e_psclk1 = 1'b1;
    always @(negedge clk) begin
        if (e_pce1 && !ce1) k1 = 0;
        if (e_psclk1 && !sclk1 && !ce1) begin
            sout1 = (k1 < 3) ? exp1_val[k1] : 1'b0;
            k1++;
        end
        e_pce1   = ce1;
        e_psclk1 = sclk1;
    end

    // Monitor / scoreboard for instance 0.
    logic       m_pce = 1'b1, m_psclk = 1'b1, in_x = 1'b0;
    int         fall_cyc = 0, nb = 0;
    logic [6:0] word = '0;
    logic [2:0] mrd = '0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            in_x = 1'b0;
            mrd  = '0;
        end else begin
            if (m_pce && !ce0) begin
                in_x     = 1'b1;
                fall_cyc = cyc;
                nb       = 0;
                word     = '0;
            end
            if (in_x && !m_psclk && sclk0) begin
                word = {word[5:0], sin0};
                nb++;
            end
            if (done0) begin
                chk("done_expected", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sin_word", word, e.word);
                    chk("bit_count", nb, 7);
                    chk("rdata", rdata0, e.rd);
                    chk("ce_fall_cycle", fall_cyc, e.acc + 1);
                    chk("done_cycle", cyc, e.acc + 37);
                    mrd = e.rd;
                end
                in_x = 1'b0;
            end else begin
                chk("rdata_hold", rdata0, mrd);
                if (sb.size() > 0 && cyc > sb[0].acc + 45) begin
                    chk("done_timeout", done0, 1);
                    void'(sb.pop_front());
                end
            end
        end
        m_pce   = ce0;
        m_psclk = sclk0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic host(input logic [6:0] w, input logic [2:0] rd, input int gap);
        int n;
        n = cyc;
        req0   = 1'b1;
        wdata0 = w;
        expect_xfer(n, w, rd);
        model_outq = w;
        tick();
        req0 = 1'b0;
        wait_until(n + 37 + gap);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         n, p;
        logic [6:0] w;
        logic [2:0] r1, r2;
        logic [13:0] sc_pat;
        logic [6:0]  w1;
        logic        psc;
        int          done_at;
        logic [2:0]  rd_at;

        reset = 1'b1;
        req0 = 1'b0; wdata0 = '0; poll_en0 = 1'b0;
        req1 = 1'b0; wdata1 = '0; poll_en1 = 1'b0;
        tick(); tick(); tick();

        chk("rst_sclk", sclk0, 1);
        chk("rst_ce", ce0, 1);
        chk("rst_sin", sin0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_rdata", rdata0, 0);
        chk("rst1_sclk", sclk1, 1);
        chk("rst1_ce", ce1, 1);

        reset = 1'b0;
        tick(); tick();

        // basic transfer
        host(7'h55, 3'b101, 2);

        // req held across a transfer, wdata changed mid-transfer
        n  = cyc;
        r1 = 3'($urandom);
        r2 = 3'($urandom);
        req0   = 1'b1;
        wdata0 = 7'h55;
        expect_xfer(n, 7'h55, r1);
        expect_xfer(n + 37, 7'h7F, r2);
        wait_until(n + 10);
        wdata0 = 7'h7F;
        wait_until(n + 38);
        req0 = 1'b0;
        model_outq = 7'h7F;
        wait_until(n + 74 + 1);

        // random host traffic, including back-to-back starts in the done cycle
        repeat (8) host(7'($urandom), 3'($urandom), int'($urandom_range(0, 4)));

        // periodic polls resend out_q
        p = cyc;
        poll_en0 = 1'b1;
        expect_xfer(p + 50,  model_outq, 3'($urandom));
        expect_xfer(p + 137, model_outq, 3'($urandom));
        expect_xfer(p + 224, model_outq, 3'($urandom));
        wait_until(p + 262);
        poll_en0 = 1'b0;
        tick(); tick();

        // req collides with poll_pending
        p = cyc;
        poll_en0 = 1'b1;
        w = 7'($urandom);
        expect_xfer(p + 50,  w, 3'($urandom));
        expect_xfer(p + 137, w, 3'($urandom));
        wait_until(p + 50);
        chk("poll_pending_set", dut0.u_poll.poll_pending, 1);
        req0   = 1'b1;
        wdata0 = w;
        tick();
        req0 = 1'b0;
        model_outq = w;
        chk("poll_pending_clear", dut0.u_poll.poll_pending, 0);
        wait_until(p + 175);
        poll_en0 = 1'b0;
        tick(); tick();

        // reset during bit 3
        n = cyc;
        req0   = 1'b1;
        wdata0 = 7'($urandom);
        exp_q0.push_back(3'($urandom));
        tick();
        req0 = 1'b0;
        wait_until(n + 17);
        chk("bit3_sclk_low", sclk0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_ce", ce0, 1);
        chk("midrst_sclk", sclk0, 1);
        chk("midrst_busy", busy0, 0);
        chk("midrst_rdata", rdata0, 0);
        chk("midrst_done", done0, 0);
        tick();
        reset = 1'b0;
        model_outq = '0;
        repeat (45) tick();

        // first transfer after reset has a full setup phase
        host(7'($urandom), 3'($urandom), 1);

        // fastest timing on instance 1
        n        = cyc;
        w        = 7'($urandom);
        exp1_val = 3'($urandom);
        req1     = 1'b1;
        wdata1   = w;
        tick();
        req1    = 1'b0;
        sc_pat  = '0;
        w1      = '0;
        psc     = 1'b1;
        done_at = -1;
        rd_at   = '0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c >= 4 && c <= 17) sc_pat = {sc_pat[12:0], sclk1};
            if (!psc && sclk1) w1 = {w1[5:0], sin1};
            psc = sclk1;
            if (done1 && done_at < 0) begin
                done_at = cyc - n;
                rd_at   = rdata1;
            end
        end
        chk("div1_done_cycle", done_at, 21);
        chk("div1_sclk_pattern", sc_pat, 14'b01010101010101);
        chk("div1_sin_word", w1, w);
        chk("div1_rdata", rd_at, exp1_val);

        repeat (5) tick();
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
